// File: rtl/ad9228_tx_emulator.sv
// AD9228-style serial transmitter: one-entry staging register feeding an MSB-first
// shifter, with DDR bit clock (DCO) and frame clock (FCO) generated from a 2x fabric clock.
module ad9228_tx_emulator #(
    parameter int                        DATA_WIDTH   = 12,
    parameter logic [DATA_WIDTH-1:0]     IDLE_PATTERN = {DATA_WIDTH{1'b0}},
    parameter int                        COUNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         clr_status,
    output logic                         dout,
    output logic                         fco,
    output logic                         dco,
    output logic                         underflow,
    output logic [COUNT_WIDTH-1:0]       words_sent
);

    localparam int                HALF_BITS = 2 * DATA_WIDTH;
    localparam int                HB_W      = $clog2(HALF_BITS);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HALF_BITS - 1);
    localparam logic [HB_W-1:0]   FCO_END   = HB_W'(DATA_WIDTH);

    generate
        if (((DATA_WIDTH % 2) != 0) || (DATA_WIDTH < 4)) begin : g_bad_width
            $error("ad9228_tx_emulator: DATA_WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [HB_W-1:0]         r_hb;
    logic [HB_W-1:0]         w_hb_nxt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;
    logic [DATA_WIDTH-1:0]   r_stage;
    logic                    r_stage_full;
    logic                    r_underflow;
    logic [COUNT_WIDTH-1:0]  r_words_sent;
    logic                    r_dout;
    logic                    r_fco;
    logic                    r_dco;
    logic                    w_load_stage;
    logic                    w_load_idle;
    logic                    w_accept;
    logic                    w_run_nxt;
    logic                    w_dout_nxt;
    logic                    w_fco_nxt;
    logic                    w_dco_nxt;

    // Accept only into an empty stage, so accept and consume are mutually exclusive.
    assign w_accept = s_valid && !r_stage_full;

    // State, half-bit counter and shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_hb    <= {HB_W{1'b0}};
            r_shift <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_hb    <= w_hb_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: start, advance half-bits, and decide what to load at each word boundary.
    always_comb begin
        w_state_nxt  = r_state;
        w_hb_nxt     = r_hb;
        w_shift_nxt  = r_shift;
        w_load_stage = 1'b0;
        w_load_idle  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hb_nxt = {HB_W{1'b0}};
                if (en && r_stage_full) begin
                    w_state_nxt  = ST_RUN;
                    w_shift_nxt  = r_stage;
                    w_load_stage = 1'b1;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_hb == HB_LAST) begin
                    w_hb_nxt = {HB_W{1'b0}};
                    if (!en) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_stage_full) begin
                        w_shift_nxt  = r_stage;
                        w_load_stage = 1'b1;
                    end else begin
                        w_shift_nxt  = IDLE_PATTERN;
                        w_load_idle  = 1'b1;
                    end
                end else begin
                    w_hb_nxt = r_hb + HB_W'(1);
                    // A bit occupies two half-bits; advance after the odd one.
                    if (r_hb[0]) begin
                        w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        w_shift_nxt = r_shift;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hb_nxt    = {HB_W{1'b0}};
            end
        endcase
    end

    // Output decode from next-state values so all three lines are registered on one edge.
    always_comb begin
        w_run_nxt  = (w_state_nxt == ST_RUN);
        w_dout_nxt = 1'b0;
        w_fco_nxt  = 1'b0;
        w_dco_nxt  = 1'b0;
        if (w_run_nxt) begin
            w_dout_nxt = w_shift_nxt[DATA_WIDTH-1];
            w_fco_nxt  = (w_hb_nxt < FCO_END);
            // hb mod 4 in {1,2} puts both DCO edges at mid-bit.
            w_dco_nxt  = w_hb_nxt[1] ^ w_hb_nxt[0];
        end else begin
            w_dout_nxt = 1'b0;
            w_fco_nxt  = 1'b0;
            w_dco_nxt  = 1'b0;
        end
    end

    // Serial output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout <= 1'b0;
            r_fco  <= 1'b0;
            r_dco  <= 1'b0;
        end else begin
            r_dout <= w_dout_nxt;
            r_fco  <= w_fco_nxt;
            r_dco  <= w_dco_nxt;
        end
    end

    // One-entry staging register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stage_full <= 1'b0;
            r_stage      <= {DATA_WIDTH{1'b0}};
        end else if (w_load_stage) begin
            r_stage_full <= 1'b0;
        end else if (w_accept) begin
            r_stage_full <= 1'b1;
            r_stage      <= s_data;
        end else begin
            r_stage_full <= r_stage_full;
        end
    end

    // Sticky underflow (set beats clear) and wrapping word counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_underflow  <= 1'b0;
            r_words_sent <= {COUNT_WIDTH{1'b0}};
        end else begin
            if (w_load_idle) begin
                r_underflow <= 1'b1;
            end else if (clr_status) begin
                r_underflow <= 1'b0;
            end else begin
                r_underflow <= r_underflow;
            end
            if (w_load_stage) begin
                r_words_sent <= r_words_sent + COUNT_WIDTH'(1);
            end else begin
                r_words_sent <= r_words_sent;
            end
        end
    end

    assign s_ready    = ~r_stage_full;
    assign dout       = r_dout;
    assign fco        = r_fco;
    assign dco        = r_dco;
    assign underflow  = r_underflow;
    assign words_sent = r_words_sent;

endmodule

// File: tb/tb_ad9228_tx_emulator.sv
// Directed bench for ad9228_tx_emulator: per-cycle waveform model plus a DCO/FCO
// deserializer that pops expected words from a scoreboard queue.
module tb_ad9228_tx_emulator;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        clr_status;
    logic        dout;
    logic        fco;
    logic        dco;
    logic        underflow;
    logic [15:0] words_sent;

    int checks   = 0;
    int failures = 0;
    int rx_words = 0;

    logic [11:0] rx_q[$];
    logic [11:0] cyc_q[$];

    ad9228_tx_emulator dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .clr_status (clr_status),
        .dout       (dout),
        .fco        (fco),
        .dco        (dco),
        .underflow  (underflow),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", 32'(n < 100), 32'd1);
    endtask

    // Stage one word; caller is 1 time unit after a posedge.
    task automatic send(input logic [11:0] w);
        wait_ready();
        s_data  = w;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        rx_q.push_back(w);
        cyc_q.push_back(w);
    endtask

    task automatic push_idle();
        rx_q.push_back(12'h000);
        cyc_q.push_back(12'h000);
    endtask

    // Cycle-level reference waveform; starts 1 time unit after the hb=0 edge.
    task automatic check_cycles(input int nw);
        logic [11:0] w;
        for (int i = 0; i < nw; i++) begin
            w = (cyc_q.size() > 0) ? cyc_q.pop_front() : 12'h000;
            for (int hb = 0; hb < 24; hb++) begin
                chk("cyc_dout", 32'(dout), 32'(w[11 - hb / 2]));
                chk("cyc_fco",  32'(fco),  32'(hb < 12));
                chk("cyc_dco",  32'(dco),  32'((hb % 4 == 1) || (hb % 4 == 2)));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic chk_idle_lines(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_fco"},  32'(fco),  32'd0);
        chk({tag, "_dco"},  32'(dco),  32'd0);
    endtask

    // Receiver: even bits on DCO rise, odd bits on DCO fall, word starts at first FCO-high rise.
    initial begin : receiver
        logic        prev_dco;
        logic        prev_fco;
        logic        active;
        int          cnt;
        logic [11:0] sh;
        logic [12:0] exp;
        prev_dco = 1'b0;
        prev_fco = 1'b0;
        active   = 1'b0;
        cnt      = 0;
        sh       = 12'h000;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_dco = 1'b0;
                prev_fco = 1'b0;
                active   = 1'b0;
                cnt      = 0;
            end else begin
                if (dco && !prev_dco) begin
                    if (fco && !prev_fco) begin
                        active = 1'b1;
                        cnt    = 1;
                        sh     = {11'h000, dout};
                    end else if (active) begin
                        sh  = {sh[10:0], dout};
                        cnt = cnt + 1;
                    end
                    prev_fco = fco;
                end else if (!dco && prev_dco && active) begin
                    sh  = {sh[10:0], dout};
                    cnt = cnt + 1;
                end
                prev_dco = dco;
                if (active && cnt == 12) begin
                    exp = (rx_q.size() > 0) ? {1'b0, rx_q.pop_front()} : 13'h1000;
                    chk("rx_word", 32'({1'b0, sh}), 32'(exp));
                    rx_words++;
                    active = 1'b0;
                    cnt    = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rstn       = 1'b0;
        en         = 1'b0;
        s_data     = 12'h000;
        s_valid    = 1'b0;
        clr_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_lines("rst");
        chk("rst_s_ready",    32'(s_ready),    32'd1);
        chk("rst_words_sent", 32'(words_sent), 32'd0);
        chk("rst_underflow",  32'(underflow),  32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single word followed by an underflow idle word.
        en = 1'b1;
        send(12'hA5C);
        push_idle();
        @(posedge clk); #1;
        fork
            check_cycles(2);
            begin
                repeat (24) @(posedge clk);
                #1;
                chk("single_underflow",  32'(underflow),  32'd1);
                chk("single_words_sent", 32'(words_sent), 32'd1);
                chk("single_s_ready",    32'(s_ready),    32'd1);
                en = 1'b0;
            end
        join
        chk_idle_lines("single_end");
        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
        chk("clr_alone", 32'(underflow), 32'd0);

        // Back-to-back words kept staged.
        send(12'h000);
        en = 1'b1;
        @(posedge clk); #1;
        fork
            check_cycles(3);
            begin
                send(12'hFFF);
                send(12'h800);
                wait_ready();
                en = 1'b0;
            end
        join
        chk_idle_lines("b2b_end");
        chk("b2b_words_sent", 32'(words_sent), 32'd4);
        chk("b2b_underflow",  32'(underflow),  32'd0);

        // en dropped at hb=7 with a word staged.
        send(12'h3C5);
        en = 1'b1;
        @(posedge clk); #1;
        fork
            check_cycles(1);
            begin
                send(12'h5A3);
                repeat (6) @(posedge clk);
                #1;
                en = 1'b0;
            end
        join
        chk_idle_lines("endrop");
        chk("endrop_s_ready",    32'(s_ready),    32'd0);
        chk("endrop_words_sent", 32'(words_sent), 32'd5);
        repeat (3) @(posedge clk);
        #1;
        chk_idle_lines("endrop_hold");
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        check_cycles(1);
        chk_idle_lines("restart_end");
        chk("restart_words_sent", 32'(words_sent), 32'd6);
        chk("restart_s_ready",    32'(s_ready),    32'd1);

        // clr_status coinciding with an underflow insertion.
        send(12'h123);
        push_idle();
        en = 1'b1;
        @(posedge clk); #1;
        fork
            check_cycles(2);
            begin
                repeat (23) @(posedge clk);
                #1;
                chk("clr_pre_underflow", 32'(underflow), 32'd0);
                clr_status = 1'b1;
                @(posedge clk); #1;
                clr_status = 1'b0;
                chk("clr_set_wins", 32'(underflow), 32'd1);
                en = 1'b0;
            end
        join
        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
        chk("clr_later", 32'(underflow), 32'd0);

        // Random loopback stream.
        send(12'($urandom));
        en = 1'b1;
        for (int i = 1; i < 1000; i++) begin
            send(12'($urandom));
        end
        wait_ready();
        en = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        cyc_q.delete();
        chk("rx_drained",      32'(rx_q.size()), 32'd0);
        chk("rx_word_count",   32'(rx_words),    32'd1009);
        chk("rand_words_sent", 32'(words_sent),  32'd1007);
        chk("rand_underflow",  32'(underflow),   32'd0);

        // Asynchronous reset in the middle of a word.
        send(12'hABC);
        en = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #3;
        chk("prereset_fco", 32'(fco), 32'd1);
        rstn = 1'b0;
        #1;
        chk_idle_lines("async_rst");
        chk("async_rst_s_ready",    32'(s_ready),    32'd1);
        chk("async_rst_words_sent", 32'(words_sent), 32'd0);
        chk("async_rst_underflow",  32'(underflow),  32'd0);
        en = 1'b0;
        rx_q.delete();
        cyc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk_idle_lines("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
